memory_port_arbiter: RTL and testbench
======================================

Name: memory_port_arbiter

Overview:
- Shares the single request port of the functional memory model between NUM_REQUESTERS independent requesters.
- Uses round-robin arbitration and carries one transaction at a time.
- Latches the winning request, issues it to the memory port, waits for the memory's completion, then returns a one-cycle response pulse to the winner.
- Sits between cache/requester logic and the memory model in the memory-hierarchy test designs.

Parameters:
- NUM_REQUESTERS, 2, number of requester ports (2..8).
- DATA_WIDTH, 16, data width; must match the memory.
- ADDRESS_WIDTH, 3, address width; must match the memory.

Ports:
- clk_i  in  1  clock; all logic on its rising edge.
- reset_i  in  1  synchronous reset, active-high.
- req_address_i  in  NUM_REQUESTERS*ADDRESS_WIDTH  per-requester address; requester k uses slice k.
- req_valid_i  in  NUM_REQUESTERS  request pending, one bit per requester.
- req_write_i  in  NUM_REQUESTERS  1 = write, 0 = read.
- req_write_data_i  in  NUM_REQUESTERS*DATA_WIDTH  per-requester write data.
- req_accept_o  out  NUM_REQUESTERS  one-hot; pulses in the cycle the request is taken.
- resp_valid_o  out  NUM_REQUESTERS  one-hot; one-cycle pulse on completion (read or write).
- resp_read_data_o  out  DATA_WIDTH  read data; valid when resp_valid_o pulses for a read.
- resp_write_done_o  out  1  high with resp_valid_o when the completed transaction was a write.
- busy_o  out  1  high in every state except IDLE.
- mem_address_o  out  ADDRESS_WIDTH  to memory address_0_i.
- mem_address_valid_o  out  1  to memory address_valid_0_i.
- mem_write_data_o  out  DATA_WIDTH  to memory write_data_0_i.
- mem_write_data_valid_o  out  1  to memory write_data_valid_0_i.
- mem_read_write_select_o  out  1  to memory read_write_select_0_i; 1 = write.
- mem_read_data_i  in  DATA_WIDTH  from memory read_data_0_o.
- mem_read_data_valid_i  in  1  from memory read_data_valid_0_o.
- mem_write_done_i  in  1  from memory write_done_0_o.
- mem_port_ready_i  in  1  from memory port_ready_0_o.

Behaviour:
- States: IDLE, ISSUE, WAIT, RESPOND.
- Reset (reset_i high at a clock edge, any state, including mid-transaction):
  - state returns to IDLE; round-robin pointer resets to 0; latched request registers clear.
  - resp_valid_o = 0, resp_write_done_o = 0, resp_read_data_o = 0, busy_o = 0.
  - all mem_* outputs = 0; req_accept_o = 0.
  - The integration must reset the memory in the same cycle (memory reset driven by ~reset_i).
- IDLE:
  - Grant goes to the first requester with req_valid_i set, scanning from the pointer upward with wrap-around.
  - req_accept_o is combinational: the one-hot grant, only in IDLE.
  - On a grant: latch index, address, rw and write data; pointer <= (grant+1) mod NUM_REQUESTERS; next state ISSUE.
  - With no valid request, stay in IDLE; the pointer does not move.
- ISSUE:
  - mem_address_valid_o = 1; mem_read_write_select_o = latched rw; mem_write_data_valid_o = latched rw.
  - mem_address_o and mem_write_data_o come from the latched values.
  - If mem_port_ready_i = 1, go to WAIT; otherwise hold the outputs and stay.
- WAIT:
  - All mem_*valid outputs = 0.
  - Done condition: mem_port_ready_i = 1 and (rw ? mem_write_done_i : mem_read_data_valid_i).
  - On done: capture mem_read_data_i (reads only) and go to RESPOND.
  - The completion flags are never sampled in ISSUE; stale valid flags from the prior transaction are cleared by the memory on accept.
- RESPOND:
  - resp_valid_o[latched index] = 1 for exactly one cycle; resp_write_done_o = rw.
  - resp_read_data_o holds the captured data until the next read response.
  - Next state IDLE.
- A requester may drop req_valid_i after its accept pulse. Inputs in non-IDLE states are ignored; requests are never queued.
- Simultaneous requests: only one accept per IDLE cycle; others wait for a later IDLE.
- Fairness: under continuous requests from all requesters, each is served at most once every NUM_REQUESTERS transactions.
- Latency with memory defaults (READ_LATENCY 9, WRITE_LATENCY 14), accept cycle = 0:
  - read: resp_valid_o pulses in cycle 13.
  - write: resp_valid_o pulses in cycle 18.
  - next accept possible in the following cycle.

Test Plan:
- Single read from req0, addr 5, after reset → req_accept_o = 01 in cycle 0; resp_valid_o = 01 in cycle 13; resp_read_data_o = 0.
- req1 writes 0xBEEF to addr 3, then req0 reads addr 3 → write response has resp_write_done_o = 1 in cycle 18; read returns 0xBEEF.
- Both requesters hold req_valid_i continuously, 4 transactions → grant order 0,1,0,1; never two accepts in one IDLE cycle.
- mem_port_ready_i forced low for 5 cycles during ISSUE → outputs held stable; transaction completes once ready returns; no duplicate issue.
- reset_i asserted in WAIT → next cycle IDLE, all outputs 0, pointer 0; a following read from req1 completes normally.
- Stale memory read_data_valid high from a prior read, new write issued → no response until mem_write_done_i; resp_write_done_o = 1.

Source files
------------

// File: rtl/memory_port_arbiter.sv
// Round-robin arbiter that shares one memory request port among NUM_REQUESTERS clients.
// One transaction is in flight at a time; completion returns as a one-cycle response pulse.
module memory_port_arbiter #(
    parameter int NUM_REQUESTERS = 2,
    parameter int DATA_WIDTH     = 16,
    parameter int ADDRESS_WIDTH  = 3
) (
    input  logic                                    clk_i,
    input  logic                                    reset_i,
    input  logic [NUM_REQUESTERS*ADDRESS_WIDTH-1:0] req_address_i,
    input  logic [NUM_REQUESTERS-1:0]               req_valid_i,
    input  logic [NUM_REQUESTERS-1:0]               req_write_i,
    input  logic [NUM_REQUESTERS*DATA_WIDTH-1:0]    req_write_data_i,
    output logic [NUM_REQUESTERS-1:0]               req_accept_o,
    output logic [NUM_REQUESTERS-1:0]               resp_valid_o,
    output logic [DATA_WIDTH-1:0]                   resp_read_data_o,
    output logic                                    resp_write_done_o,
    output logic                                    busy_o,
    output logic [ADDRESS_WIDTH-1:0]                mem_address_o,
    output logic                                    mem_address_valid_o,
    output logic [DATA_WIDTH-1:0]                   mem_write_data_o,
    output logic                                    mem_write_data_valid_o,
    output logic                                    mem_read_write_select_o,
    input  logic [DATA_WIDTH-1:0]                   mem_read_data_i,
    input  logic                                    mem_read_data_valid_i,
    input  logic                                    mem_write_done_i,
    input  logic                                    mem_port_ready_i
);
    localparam int IDX_W = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
    localparam logic [1:0] ST_WAIT    = 2'd2;
    localparam logic [1:0] ST_RESPOND = 2'd3;

    logic [1:0]               state_reg, state_next;
    logic [IDX_W-1:0]         ptr_reg, ptr_next;
    logic [IDX_W-1:0]         idx_reg;
    logic [IDX_W-1:0]         grant_idx, cand_idx;
    logic                     grant_found;
    logic [ADDRESS_WIDTH-1:0] addr_reg;
    logic                     rw_reg;
    logic [DATA_WIDTH-1:0]    wdata_reg;
    logic [DATA_WIDTH-1:0]    rdata_reg;
    logic                     mem_done;
    logic                     issuing;

    logic [ADDRESS_WIDTH-1:0] req_addr_arr [NUM_REQUESTERS];
    logic [DATA_WIDTH-1:0]    req_data_arr [NUM_REQUESTERS];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQUESTERS; gi++) begin : g_req
            assign req_addr_arr[gi] = req_address_i[gi*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            assign req_data_arr[gi] = req_write_data_i[gi*DATA_WIDTH +: DATA_WIDTH];
            assign req_accept_o[gi] = (state_reg == ST_IDLE) && grant_found &&
                                      (grant_idx == IDX_W'(gi));
            assign resp_valid_o[gi] = (state_reg == ST_RESPOND) && (idx_reg == IDX_W'(gi));
        end
    endgenerate

    // Scan from the pointer upward with wrap-around; the first valid requester wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand_idx    = '0;
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            if ((int'(ptr_reg) + i) >= NUM_REQUESTERS) begin
                cand_idx = IDX_W'(int'(ptr_reg) + i - NUM_REQUESTERS);
            end else begin
                cand_idx = IDX_W'(int'(ptr_reg) + i);
            end
            if (!grant_found && req_valid_i[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    assign ptr_next = (grant_idx == IDX_W'(NUM_REQUESTERS - 1)) ? '0 : grant_idx + IDX_W'(1);
    assign mem_done = mem_port_ready_i && (rw_reg ? mem_write_done_i : mem_read_data_valid_i);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:    if (grant_found) state_next = ST_ISSUE;
            ST_ISSUE:   if (mem_port_ready_i) state_next = ST_WAIT;
            ST_WAIT:    if (mem_done) state_next = ST_RESPOND;
            ST_RESPOND: state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_reg <= ST_IDLE;
            ptr_reg   <= '0;
            idx_reg   <= '0;
            addr_reg  <= '0;
            rw_reg    <= 1'b0;
            wdata_reg <= '0;
            rdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == ST_IDLE && grant_found) begin
                idx_reg   <= grant_idx;
                addr_reg  <= req_addr_arr[grant_idx];
                rw_reg    <= req_write_i[grant_idx];
                wdata_reg <= req_data_arr[grant_idx];
                ptr_reg   <= ptr_next;
            end
            // Read data is held until the next read completes, so writes leave it alone.
            if (state_reg == ST_WAIT && mem_done && !rw_reg) begin
                rdata_reg <= mem_read_data_i;
            end
        end
    end

    assign issuing                 = (state_reg == ST_ISSUE);
    assign busy_o                  = (state_reg != ST_IDLE);
    assign mem_address_valid_o     = issuing;
    assign mem_address_o           = issuing ? addr_reg : '0;
    assign mem_write_data_o        = issuing ? wdata_reg : '0;
    assign mem_write_data_valid_o  = issuing && rw_reg;
    assign mem_read_write_select_o = issuing && rw_reg;
    assign resp_write_done_o       = (state_reg == ST_RESPOND) && rw_reg;
    assign resp_read_data_o        = rdata_reg;
endmodule

// File: tb/tb_memory_port_arbiter.sv
// Bench for memory_port_arbiter: a timed memory model on the port plus a round-robin
// reference model that predicts grants, read data and response latency.
module tb_memory_port_arbiter;
    localparam int N         = 2;
    localparam int DW        = 16;
    localparam int AW        = 3;
    localparam int READ_LAT  = 13;
    localparam int WRITE_LAT = 18;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [N*AW-1:0] req_address = '0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_write = '0;
    logic [N*DW-1:0] req_write_data = '0;
    logic [N-1:0]    req_accept, resp_valid;
    logic [DW-1:0]   resp_read_data;
    logic            resp_write_done, busy;
    logic [AW-1:0]   mem_address;
    logic            mem_address_valid, mem_write_data_valid, mem_read_write_select;
    logic [DW-1:0]   mem_write_data;
    logic [DW-1:0]   mem_read_data = '0;
    logic            mem_rdv_reg = 1'b0, mem_wd_reg = 1'b0;
    logic            ready_ctl = 1'b1, stale_force = 1'b0;
    logic            mem_read_data_valid;

    always #5 clk = ~clk;

    memory_port_arbiter #(.NUM_REQUESTERS(N), .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
        .clk_i(clk), .reset_i(reset),
        .req_address_i(req_address), .req_valid_i(req_valid), .req_write_i(req_write),
        .req_write_data_i(req_write_data), .req_accept_o(req_accept),
        .resp_valid_o(resp_valid), .resp_read_data_o(resp_read_data),
        .resp_write_done_o(resp_write_done), .busy_o(busy),
        .mem_address_o(mem_address), .mem_address_valid_o(mem_address_valid),
        .mem_write_data_o(mem_write_data), .mem_write_data_valid_o(mem_write_data_valid),
        .mem_read_write_select_o(mem_read_write_select), .mem_read_data_i(mem_read_data),
        .mem_read_data_valid_i(mem_read_data_valid), .mem_write_done_i(mem_wd_reg),
        .mem_port_ready_i(ready_ctl)
    );

    // Memory model: completion flags rise a fixed number of cycles after an accepted
    // request and stay high (stale) until the next accept clears them.
    logic [DW-1:0] mem_arr [8];
    int            mem_timer = 0;
    logic          mem_pending = 1'b0, mem_rw_pend = 1'b0;
    int            issue_count = 0;
    assign mem_read_data_valid = mem_rdv_reg | stale_force;

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) mem_arr[i] <= '0;
            mem_timer <= 0; mem_pending <= 1'b0; mem_rdv_reg <= 1'b0; mem_wd_reg <= 1'b0;
            mem_read_data <= '0;
        end else if (mem_address_valid && ready_ctl) begin
            issue_count <= issue_count + 1;
            mem_rdv_reg <= 1'b0; mem_wd_reg <= 1'b0; mem_pending <= 1'b1;
            mem_rw_pend <= mem_read_write_select;
            mem_timer   <= mem_read_write_select ? 15 : 10;
            if (mem_read_write_select && mem_write_data_valid) mem_arr[mem_address] <= mem_write_data;
            else mem_read_data <= mem_arr[mem_address];
        end else if (mem_pending) begin
            if (mem_timer == 1) begin
                mem_pending <= 1'b0;
                if (mem_rw_pend) mem_wd_reg <= 1'b1;
                else mem_rdv_reg <= 1'b1;
            end
            mem_timer <= mem_timer - 1;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    int            ref_ptr = 0;
    logic [DW-1:0] ref_mem [8];
    logic [DW-1:0] ref_last_rd = '0;

    function automatic int ref_winner(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[(ref_ptr + i) % N]) return (ref_ptr + i) % N;
        return -1;
    endfunction

    task automatic ref_clear();
        ref_ptr = 0;
        ref_last_rd = '0;
        for (int i = 0; i < 8; i++) ref_mem[i] = '0;
    endtask

    // Advance the model for a granted request of requester k; returns expected data/latency.
    task automatic ref_apply(input int k, output logic [DW-1:0] exp_rd, output int exp_lat);
        logic [AW-1:0] a;
        a = req_address[k*AW +: AW];
        ref_ptr = (k + 1) % N;
        if (req_write[k]) begin
            ref_mem[a] = req_write_data[k*DW +: DW];
            exp_lat = WRITE_LAT;
        end else begin
            ref_last_rd = ref_mem[a];
            exp_lat = READ_LAT;
        end
        exp_rd = ref_last_rd;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1; req_valid = '0; req_write = '0; req_address = '0; req_write_data = '0;
        ready_ctl = 1'b1; stale_force = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        ref_clear();
    endtask

    task automatic set_req(input int k, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_write[k] = w;
        req_address[k*AW +: AW] = a;
        req_write_data[k*DW +: DW] = d;
        req_valid[k] = 1'b1;
    endtask

    task automatic wait_accept(output int c, output logic [N-1:0] g);
        c = -1; g = '0;
        for (int i = 0; i < 60; i++) begin
            #1;
            if (req_accept != '0) begin c = cyc; g = req_accept; break; end
            @(negedge clk);
        end
    endtask

    task automatic wait_resp(output int c, output logic [N-1:0] v, output logic [DW-1:0] rd,
                             output logic wd);
        c = -1; v = '0; rd = '0; wd = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk); #1;
            if (resp_valid != '0) begin
                c = cyc; v = resp_valid; rd = resp_read_data; wd = resp_write_done;
                break;
            end
        end
    endtask

    task automatic release_after_edge(input logic [N-1:0] mask);
        @(posedge clk); #1;
        req_valid = req_valid & ~mask;
    endtask

    task automatic test_reset();
        apply_reset(); #1;
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++;
        if ({resp_valid, resp_write_done, resp_read_data} !== '0) begin
            failures++;
            $display("FAIL reset_resp: got %h expected 0", {resp_valid, resp_write_done, resp_read_data});
        end
        checks++;
        if ({mem_address_valid, mem_write_data_valid, mem_read_write_select, mem_address,
             mem_write_data, req_accept} !== '0) begin
            failures++;
            $display("FAIL reset_mem_outputs: got %h expected 0", {mem_address_valid,
                     mem_write_data_valid, mem_read_write_select, mem_address, mem_write_data, req_accept});
        end
    endtask

    task automatic test_single_read();
        int ac, rc, exp_lat;
        logic [N-1:0] g, v, exp_g;
        logic [DW-1:0] rd, exp_rd;
        logic wd;
        set_req(0, 1'b0, 3'd5, 16'h1234);
        exp_g = N'(1) << ref_winner(req_valid);
        wait_accept(ac, g);
        checks++;
        if (g !== exp_g) begin failures++; $display("FAIL single_read_accept: got %b expected %b", g, exp_g); end
        ref_apply(0, exp_rd, exp_lat);
        release_after_edge('1);
        wait_resp(rc, v, rd, wd);
        checks++;
        if (v !== exp_g || rc - ac !== exp_lat) begin
            failures++;
            $display("FAIL single_read_resp: got valid=%b cycle=%0d expected valid=%b cycle=%0d", v, rc - ac, exp_g, exp_lat);
        end
        checks++;
        if (rd !== exp_rd || wd !== 1'b0) begin
            failures++;
            $display("FAIL single_read_data: got data=%h wd=%b expected data=%h wd=0", rd, wd, exp_rd);
        end
        @(negedge clk); #1;
        checks++;
        if (resp_valid !== '0) begin failures++; $display("FAIL single_read_pulse: got %b expected 0", resp_valid); end
        $display("txn single_read req0 addr=5 accept=%b resp_cycle=%0d data=%h", g, rc - ac, rd);
    endtask

    task automatic test_write_then_read();
        int tk [2] = '{1, 0};
        bit tw [2] = '{1'b1, 1'b0};
        int ac, rc, exp_lat;
        logic [N-1:0] g, v, exp_g;
        logic [DW-1:0] rd, exp_rd;
        logic wd;
        for (int t = 0; t < 2; t++) begin
            set_req(tk[t], tw[t], 3'd3, 16'hBEEF);
            exp_g = N'(1) << ref_winner(req_valid);
            wait_accept(ac, g);
            checks++;
            if (g !== exp_g) begin failures++; $display("FAIL wr_rd_accept%0d: got %b expected %b", t, g, exp_g); end
            ref_apply(tk[t], exp_rd, exp_lat);
            release_after_edge('1);
            wait_resp(rc, v, rd, wd);
            checks++;
            if (v !== exp_g || rc - ac !== exp_lat || wd !== tw[t] || rd !== exp_rd) begin
                failures++;
                $display("FAIL wr_rd_resp%0d: got v=%b cyc=%0d wd=%b data=%h expected v=%b cyc=%0d wd=%b data=%h",
                         t, v, rc - ac, wd, rd, exp_g, exp_lat, tw[t], exp_rd);
            end
            $display("txn wr_rd req%0d %s addr=3 resp_cycle=%0d data=%h", tk[t], tw[t] ? "write" : "read", rc - ac, rd);
        end
    endtask

    task automatic test_back_to_back();
        int ac, rc, prev_rc, exp_lat, k;
        logic [N-1:0] g, v, exp_g;
        logic [DW-1:0] rd, exp_rd;
        logic wd;
        apply_reset();
        set_req(0, 1'b1, 3'd2, 16'hA5A5);
        set_req(1, 1'b0, 3'd2, 16'h0000);
        prev_rc = -1;
        for (int t = 0; t < 4; t++) begin
            k = ref_winner(req_valid);
            exp_g = N'(1) << k;
            wait_accept(ac, g);
            checks++;
            if (g !== exp_g) begin failures++; $display("FAIL b2b_grant%0d: got %b expected %b", t, g, exp_g); end
            if (t > 0) begin
                checks++;
                if (ac !== prev_rc + 1) begin
                    failures++;
                    $display("FAIL b2b_gap%0d: got accept cycle %0d expected %0d", t, ac, prev_rc + 1);
                end
            end
            ref_apply(k, exp_rd, exp_lat);
            @(posedge clk);
            wait_resp(rc, v, rd, wd);
            checks++;
            if (v !== exp_g || rc - ac !== exp_lat || rd !== exp_rd) begin
                failures++;
                $display("FAIL b2b_resp%0d: got v=%b cyc=%0d data=%h expected v=%b cyc=%0d data=%h",
                         t, v, rc - ac, rd, exp_g, exp_lat, exp_rd);
            end
            prev_rc = rc;
            $display("txn b2b #%0d grant=%b resp_cycle=%0d data=%h", t, g, rc - ac, rd);
        end
        req_valid = '0;
    endtask

    task automatic test_port_stall();
        int ac, rc, exp_lat, k, n0;
        logic [N-1:0] g, v, exp_g;
        logic [DW-1:0] rd, exp_rd;
        logic wd;
        @(negedge clk);
        n0 = issue_count;
        ready_ctl = 1'b0;
        set_req(1, 1'b1, 3'd6, 16'h5A5A);
        k = ref_winner(req_valid);
        exp_g = N'(1) << k;
        wait_accept(ac, g);
        checks++;
        if (g !== exp_g) begin failures++; $display("FAIL stall_accept: got %b expected %b", g, exp_g); end
        ref_apply(k, exp_rd, exp_lat);
        for (int j = 0; j < 5; j++) begin
            @(negedge clk); #1;
            if (j == 0) req_valid = '0;
            checks++;
            if ({mem_address_valid, mem_read_write_select, mem_write_data_valid, mem_address, mem_write_data}
                    !== {3'b111, 3'd6, 16'h5A5A}) begin
                failures++;
                $display("FAIL stall_hold%0d: got %h expected %h", j, {mem_address_valid, mem_read_write_select,
                         mem_write_data_valid, mem_address, mem_write_data}, {3'b111, 3'd6, 16'h5A5A});
            end
        end
        @(negedge clk);
        ready_ctl = 1'b1;
        wait_resp(rc, v, rd, wd);
        checks++;
        if (v !== exp_g || rc - ac !== exp_lat + 5 || wd !== 1'b1) begin
            failures++;
            $display("FAIL stall_resp: got v=%b cyc=%0d wd=%b expected v=%b cyc=%0d wd=1", v, rc - ac, wd, exp_g, exp_lat + 5);
        end
        checks++;
        if (issue_count - n0 !== 1) begin
            failures++;
            $display("FAIL stall_issue_count: got %0d expected 1", issue_count - n0);
        end
        $display("txn stall req%0d write addr=6 resp_cycle=%0d", k, rc - ac);
    endtask

    task automatic test_reset_mid();
        int ac, rc, exp_lat, k;
        logic [N-1:0] g, v, exp_g;
        logic [DW-1:0] rd, exp_rd;
        logic wd;
        @(negedge clk);
        set_req(0, 1'b0, 3'd1, 16'h0000);
        k = ref_winner(req_valid);
        wait_accept(ac, g);
        ref_apply(k, exp_rd, exp_lat);
        release_after_edge('1);
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL midreset_busy_before: got %b expected 1", busy); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        ref_clear();
        #1;
        checks++;
        if ({busy, resp_valid, resp_write_done, resp_read_data, mem_address_valid, mem_address,
             mem_write_data_valid, mem_read_write_select, req_accept} !== '0) begin
            failures++;
            $display("FAIL midreset_outputs: got %h expected 0", {busy, resp_valid, resp_write_done,
                     resp_read_data, mem_address_valid, mem_address, mem_write_data_valid,
                     mem_read_write_select, req_accept});
        end
        @(negedge clk);
        set_req(0, 1'b0, 3'd4, 16'h0000);
        set_req(1, 1'b0, 3'd5, 16'h0000);
        for (int t = 0; t < 2; t++) begin
            k = ref_winner(req_valid);
            exp_g = N'(1) << k;
            wait_accept(ac, g);
            checks++;
            if (g !== exp_g) begin failures++; $display("FAIL midreset_grant%0d: got %b expected %b", t, g, exp_g); end
            ref_apply(k, exp_rd, exp_lat);
            release_after_edge(exp_g);
            wait_resp(rc, v, rd, wd);
            checks++;
            if (v !== exp_g || rc - ac !== exp_lat || rd !== exp_rd) begin
                failures++;
                $display("FAIL midreset_resp%0d: got v=%b cyc=%0d data=%h expected v=%b cyc=%0d data=%h",
                         t, v, rc - ac, rd, exp_g, exp_lat, exp_rd);
            end
            $display("txn after_reset req%0d read resp_cycle=%0d data=%h", k, rc - ac, rd);
        end
    endtask

    task automatic test_stale_flag();
        int ac, rc, exp_lat, k;
        logic [N-1:0] g, v, exp_g;
        logic [DW-1:0] rd, exp_rd;
        logic wd;
        @(negedge clk);
        stale_force = 1'b1;
        set_req(0, 1'b1, 3'd7, 16'hC0DE);
        k = ref_winner(req_valid);
        exp_g = N'(1) << k;
        wait_accept(ac, g);
        ref_apply(k, exp_rd, exp_lat);
        release_after_edge('1);
        wait_resp(rc, v, rd, wd);
        stale_force = 1'b0;
        checks++;
        if (v !== exp_g || rc - ac !== exp_lat || wd !== 1'b1) begin
            failures++;
            $display("FAIL stale_write_resp: got v=%b cyc=%0d wd=%b expected v=%b cyc=%0d wd=1", v, rc - ac, wd, exp_g, exp_lat);
        end
        $display("txn stale write req%0d addr=7 resp_cycle=%0d wd=%b", k, rc - ac, wd);
    endtask

    task automatic test_random();
        int ac, rc, exp_lat, k;
        logic [N-1:0] g, v, exp_g, mask;
        logic [DW-1:0] rd, exp_rd;
        logic wd;
        for (int it = 0; it < 24; it++) begin
            @(negedge clk);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            mask = N'($urandom_range(1, (1 << N) - 1));
            for (int j = 0; j < N; j++)
                if (mask[j]) set_req(j, bit'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), DW'($urandom));
            k = ref_winner(req_valid);
            exp_g = N'(1) << k;
            wait_accept(ac, g);
            checks++;
            if (g !== exp_g) begin failures++; $display("FAIL rand_grant%0d: got %b expected %b", it, g, exp_g); end
            ref_apply(k, exp_rd, exp_lat);
            release_after_edge('1);
            wait_resp(rc, v, rd, wd);
            checks++;
            if (v !== exp_g || rc - ac !== exp_lat || rd !== exp_rd || wd !== (exp_lat == WRITE_LAT)) begin
                failures++;
                $display("FAIL rand_resp%0d: got v=%b cyc=%0d data=%h wd=%b expected v=%b cyc=%0d data=%h",
                         it, v, rc - ac, rd, wd, exp_g, exp_lat, exp_rd);
            end
            $display("txn rand #%0d mask=%b grant=%b resp_cycle=%0d data=%h wd=%b", it, mask, g, rc - ac, rd, wd);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_read();
        test_write_then_read();
        test_back_to_back();
        test_port_stall();
        test_reset_mid();
        test_stale_flag();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
